shift_add_mul4: RTL and testbench

Sequential shift-and-add multiplier that forms the 2N-bit product of two N-bit operands over N iterations. It produces the product word and the one-cycle load strobe consumed by the downstream 8-bit product register (`register_8bit`, driven through its `in`/`ld` inputs). It is the arithmetic stage of the 4x4 multiplier datapath, started by a one-cycle `start` from the top-level controller.

---
 rtl/mul4_pkg.sv | 18 +
 rtl/addsub_nbit.sv | 13 +
 rtl/shift_add_mul4.sv | 104 ++++++++++
 tb/tb_shift_add_mul4.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mul4_pkg.sv
// rtl/mul4_pkg.sv - shared types and width constants for the shift-add multiplier
package mul4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int MUL_N = 4;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int MUL_CNT_W = cnt_w(MUL_N);

endpackage

// File: rtl/addsub_nbit.sv
// rtl/addsub_nbit.sv - (N+1)-bit combinational adder/subtractor for the accumulate step
module addsub_nbit #(
    parameter int N = 4
) (
    input  logic [N:0] x,
    input  logic [N:0] y,
    input  logic       sub,
    output logic [N:0] sum
);

    assign sum = sub ? (x - y) : (x + y);

endmodule

// File: rtl/shift_add_mul4.sv
// rtl/shift_add_mul4.sv - sequential shift-and-add multiplier; MUL_SIGNED_EN selects two's complement
module shift_add_mul4
    import mul4_pkg::*;
#(
    parameter int N = MUL_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic           product_ld
);

    localparam int CW = cnt_w(N);

    state_t          state, state_nxt;
    logic [N-1:0]    m;
    logic [2*N:0]    acc;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            sub;
    logic [N:0]      addend;
    logic [N:0]      sum;
    logic [N:0]      upper;
    logic [2*N:0]    acc_shift;

    assign last = (cnt == CW'(N - 1));

`ifdef MUL_SIGNED_EN
    // Top multiplier bit carries negative weight, so the last step subtracts.
    assign addend = {m[N-1], m};
    assign sub    = last;
`else
    assign addend = {1'b0, m};
    assign sub    = 1'b0;
`endif

    addsub_nbit #(.N(N)) u_addsub (
        .x   (acc[2*N:N]),
        .y   (addend),
        .sub (sub),
        .sum (sum)
    );

    assign upper = acc[0] ? sum : acc[2*N:N];

`ifdef MUL_SIGNED_EN
    assign acc_shift = {upper[N], upper, acc[N-1:1]};
`else
    assign acc_shift = {1'b0, upper, acc[N-1:1]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m       <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        acc <= {{(N + 1){1'b0}}, b};
                        cnt <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_shift;
                    cnt <= cnt + CW'(1);
                    if (last) product <= acc_shift[2*N-1:0];
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign product_ld = done;

endmodule

// File: tb/tb_shift_add_mul4.sv
// tb/tb_shift_add_mul4.sv - scoreboard bench for shift_add_mul4 with a downstream 8-bit load register
module tb_shift_add_mul4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic       product_ld;
    logic [7:0] product;
    logic [7:0] reg_out;

    logic [7:0] exp_q[$];
    logic [7:0] last_exp;
    logic       have_result;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    shift_add_mul4 #(.N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .product_ld (product_ld)
    );

    // Behavioural stand-in for the downstream register_8bit (in/ld/out).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) reg_out <= '0;
        else if (product_ld) reg_out <= product;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done and tracks the downstream register.
    initial begin
        have_result = 1'b0;
        last_exp    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_result = 1'b0;
                if (done) check("done_in_reset", done, 1'b0);
            end else begin
                if (have_result) check("reg8_out", reg_out, last_exp);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=%0h required=none", product);
                    end else begin
                        last_exp = exp_q.pop_front();
                        have_result = 1'b1;
                        check("product", product, last_exp);
                        check("product_ld", product_ld, done);
                    end
                end
            end
        end
    end

    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic [7:0] e,
                          output int lat, output int bcyc, output int dcyc);
        lat  = 0;
        bcyc = 0;
        dcyc = 0;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = ~ta;
        b     = ~tb_v;
        for (int i = 1; i <= 30; i++) begin
            if (busy) bcyc++;
            if (done) begin
                dcyc++;
                if (lat == 0) lat = i;
            end
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    logic [3:0] op_a[6];
    logic [3:0] op_b[6];
    logic [7:0] op_e[6];
    logic [3:0] ha[13];
    logic [3:0] hb[13];

    initial begin
        int lat, bcyc, dcyc;

        op_a[0] = 4'h3; op_b[0] = 4'h7; op_e[0] = 8'h15;
        op_a[1] = 4'hF; op_b[1] = 4'hF;
        op_a[2] = 4'h0; op_b[2] = 4'h9; op_e[2] = 8'h00;
        op_a[3] = 4'h9; op_b[3] = 4'h1;
        op_a[4] = 4'hD; op_b[4] = 4'h5;
        op_a[5] = 4'h8; op_b[5] = 4'h8; op_e[5] = 8'h40;
`ifdef MUL_SIGNED_EN
        op_e[1] = 8'h01; op_e[3] = 8'hF9; op_e[4] = 8'hF1;
`else
        op_e[1] = 8'hE1; op_e[3] = 8'h09; op_e[4] = 8'h41;
`endif

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_product_ld", product_ld, 1'b0);
        check("rst_product", product, 8'h00);
        rst = 1'b0;

        // Abort a multiply two cycles into CALC.
        @(negedge clk);
        start = 1'b1;
        a     = 4'h3;
        b     = 4'h7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_product_ld", product_ld, 1'b0);
        check("abort_product", product, 8'h00);
        repeat (6) @(negedge clk);
        check("abort_no_done", done, 1'b0);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run_op(op_a[k], op_b[k], op_e[k], lat, bcyc, dcyc);
            check("latency", lat, 5);
            check("busy_cycles", bcyc, 5);
            check("done_cycles", dcyc, 1);
        end

        // Start held high with operands changing every cycle.
        for (int i = 0; i < 13; i++) begin
            ha[i] = 4'(i + 10);
            hb[i] = 4'(3 * i + 1);
        end
        ha[0]  = 4'h2; hb[0]  = 4'h3;
        ha[6]  = 4'h5; hb[6]  = 4'h6;
        ha[12] = 4'h7; hb[12] = 4'h7;
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h1E);
        exp_q.push_back(8'h31);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            start = 1'b1;
            a     = ha[i];
            b     = hb[i];
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(negedge clk);
        end
        check("held_queue_drained", exp_q.size(), 0);
        check("held_idle", busy, 1'b0);
        repeat (8) @(negedge clk);
        check("held_no_extra", done, 1'b0);
        check("reg8_final", reg_out, 8'h31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
